keynsham_bus_arbiter: RTL and testbench
=======================================

Name: keynsham_bus_arbiter

Overview:
Two-master to one-slave arbiter for the Keynsham SoC. It shares a single slave port, such as the SDRAM controller's bus port, between the CPU instruction bus (i_*) and data bus (d_*).
- Uses the SoC access/ack/error handshake on both sides.
- Round-robin grant, one outstanding transaction at a time.
- Converts a non-responding slave into an ack+error using a watchdog timeout.

Parameters:
TIMEOUT, 256, cycles allowed in WAIT before a forced error completion; 0 disables the timeout.
CNT_W, 9, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous, active-high
i_access  in  1  instruction request pulse; i_addr held stable until i_ack
i_addr  in  30  instruction word address
i_data  out  32  read data, valid only while i_ack=1
i_ack  out  1  one-cycle completion pulse
i_error  out  1  error qualifier, valid with i_ack
d_access  in  1  data request pulse; address/write fields held stable until d_ack
d_addr  in  30  data word address
d_wr_val  in  32  write data
d_wr_en  in  1  1 = write
d_bytesel  in  4  byte enables
d_data  out  32  read data, valid while d_ack=1
d_ack  out  1  completion pulse
d_error  out  1  error qualifier, valid with d_ack
m_access  out  1  slave request pulse
m_addr  out  30  slave address (registered)
m_wr_val  out  32  slave write data (registered)
m_wr_en  out  1  slave write enable (registered)
m_bytesel  out  4  slave byte enables (registered)
m_data  in  32  slave read data, valid with m_ack
m_ack  in  1  slave completion pulse
m_error  in  1  slave error, valid with m_ack

Behaviour:
Reset (async, rst=1):
- All outputs 0; i_pend=d_pend=0; state=IDLE; last_grant=I, so D wins the first tie; timeout counter=0.

Pending latches:
- x_access sets x_pend on the next edge.
- x_pend clears on the edge on which x_ack is driven.
- An x_access arriving while x_pend=1 and not in its ack cycle is a protocol violation: ignored, no double count.
- An x_access in the same cycle as its own x_ack sets x_pend again (set wins).

FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE, no pend: stay.
- IDLE, one pend: grant that master.
- IDLE, both pend: grant the master != last_grant.
- On grant: register m_addr/m_wr_val/m_wr_en/m_bytesel from the granted master. For I the write fields are wr_en=0, bytesel=4'b1111, wr_val=0. Go to ISSUE.
- ISSUE: m_access=1 for exactly this cycle; clear counter; go to WAIT.
- WAIT, m_ack=1: capture m_data and m_error; go to RESP.
- WAIT, TIMEOUT!=0 and counter==TIMEOUT-1 without m_ack: captured data=0, error=1; go to RESP.
- WAIT, otherwise: counter+1.
- RESP: granted x_ack=1 for one cycle with registered x_data/x_error; update last_grant; go to IDLE.

Latency:
- x_access at cycle N gives m_access at N+2 when the arbiter is idle.
- m_ack at T gives x_ack at T+1.
- Next m_access no earlier than T+3.

Other rules:
- m_ack outside WAIT is ignored.
- m_addr and the write fields hold their value after the transaction.
- m_access is never asserted while a transaction is outstanding.
- Non-granted x_ack/x_error stay 0.
- x_data/x_error read 0 when x_ack=0.
- rst asserted mid-transaction: immediate return to IDLE, pendings lost, no ack issued. A late m_ack after reset is ignored.

Test Plan:
1. Single D read: d_access at cycle 0, addr=0x2000010 -> m_access at cycle 2 with m_addr=0x2000010, m_wr_en=0. Slave acks at cycle 5 with m_data=0xDEADBEEF -> d_ack=1 and d_data=0xDEADBEEF at cycle 6, d_error=0.
2. Simultaneous i_access and d_access from reset -> D served first, then I; their m_access pulses are separated by the D latency plus 3. A repeat pair is served I then D (alternation).
3. D write: wr_val=0x12345678, bytesel=4'b0011 -> m_wr_val/m_bytesel/m_wr_en match on the m_access cycle. An I request arriving mid-write waits, and i_ack follows the write's d_ack.
4. Timeout, TIMEOUT=4, slave silent -> i_ack=1, i_error=1, i_data=0 exactly 5 cycles after m_access. A late m_ack is ignored.
5. Slave m_error=1 with m_ack -> d_ack=1, d_error=1. The arbiter then serves the next pending request normally.
6. rst pulsed while in WAIT -> all outputs 0 asynchronously, no x_ack. A subsequent request completes normally.

Source files
------------

// File: rtl/keynsham_bus_arbiter.sv
// Two-master (instruction/data) to one-slave bus arbiter.
// Round-robin between the masters, one outstanding slave transaction at a time,
// and a watchdog that turns a silent slave into an ack+error completion.
module keynsham_bus_arbiter #(
    parameter int unsigned TIMEOUT = 256,
    parameter int unsigned CNT_W   = 9
) (
    input  logic        clk,
    input  logic        rst,
    // instruction master
    input  logic        i_access,
    input  logic [29:0] i_addr,
    output logic [31:0] i_data,
    output logic        i_ack,
    output logic        i_error,
    // data master
    input  logic        d_access,
    input  logic [29:0] d_addr,
    input  logic [31:0] d_wr_val,
    input  logic        d_wr_en,
    input  logic [3:0]  d_bytesel,
    output logic [31:0] d_data,
    output logic        d_ack,
    output logic        d_error,
    // slave port
    output logic        m_access,
    output logic [29:0] m_addr,
    output logic [31:0] m_wr_val,
    output logic        m_wr_en,
    output logic [3:0]  m_bytesel,
    input  logic [31:0] m_data,
    input  logic        m_ack,
    input  logic        m_error
);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StResp
    } state_e;

    // Last counter value still inside the watchdog window.
    localparam logic [CNT_W-1:0] CntLast = CNT_W'(TIMEOUT - 1);

    state_e           state_q, state_d;
    logic             i_pend_q, i_pend_d;
    logic             d_pend_q, d_pend_d;
    logic             gnt_data_q, gnt_data_d;   // 1: data master owns the slave
    logic             last_data_q, last_data_d; // 1: data master was served last
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [29:0]      addr_q, addr_d;
    logic [31:0]      wr_val_q, wr_val_d;
    logic             wr_en_q, wr_en_d;
    logic [3:0]       bytesel_q, bytesel_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             rerr_q, rerr_d;
    logic             resp;
    logic             timeout_hit;
    logic             pick_data;

    // Master-facing responses and the slave request, all decoded from registered state.
    always_comb begin
        resp      = (state_q == StResp);
        i_ack     = resp && !gnt_data_q;
        d_ack     = resp && gnt_data_q;
        i_data    = i_ack ? rdata_q : 32'h0;
        i_error   = i_ack && rerr_q;
        d_data    = d_ack ? rdata_q : 32'h0;
        d_error   = d_ack && rerr_q;
        m_access  = (state_q == StIssue);
        m_addr    = addr_q;
        m_wr_val  = wr_val_q;
        m_wr_en   = wr_en_q;
        m_bytesel = bytesel_q;
    end

    // Pending latches: a new request wins over the clear in its own ack cycle,
    // and a repeat request while already pending just leaves the latch set.
    always_comb begin
        i_pend_d = i_access | (i_pend_q & ~i_ack);
        d_pend_d = d_access | (d_pend_q & ~d_ack);
    end

    // Watchdog expiry; TIMEOUT of zero disables it entirely.
    always_comb begin
        timeout_hit = (TIMEOUT != 0) && (cnt_q == CntLast);
    end

    // Round-robin choice: data wins when it is the only requester or when
    // instruction was served last.
    always_comb begin
        pick_data = d_pend_q && (!i_pend_q || !last_data_q);
    end

    // Next-state and datapath for the transaction sequencer.
    always_comb begin
        state_d     = state_q;
        gnt_data_d  = gnt_data_q;
        last_data_d = last_data_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wr_val_d    = wr_val_q;
        wr_en_d     = wr_en_q;
        bytesel_d   = bytesel_q;
        rdata_d     = rdata_q;
        rerr_d      = rerr_q;

        case (state_q)
            StIdle: begin
                if (i_pend_q || d_pend_q) begin
                    gnt_data_d = pick_data;
                    if (pick_data) begin
                        addr_d    = d_addr;
                        wr_val_d  = d_wr_val;
                        wr_en_d   = d_wr_en;
                        bytesel_d = d_bytesel;
                    end else begin
                        // Instruction fetches are always full-word reads.
                        addr_d    = i_addr;
                        wr_val_d  = 32'h0;
                        wr_en_d   = 1'b0;
                        bytesel_d = 4'b1111;
                    end
                    state_d = StIssue;
                end
            end

            StIssue: begin
                cnt_d   = '0;
                state_d = StWait;
            end

            StWait: begin
                if (m_ack) begin
                    rdata_d = m_data;
                    rerr_d  = m_error;
                    state_d = StResp;
                end else if (timeout_hit) begin
                    rdata_d = 32'h0;
                    rerr_d  = 1'b1;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            StResp: begin
                last_data_d = gnt_data_q;
                state_d     = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State register; reset abandons any transaction and drops pending requests.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            i_pend_q    <= 1'b0;
            d_pend_q    <= 1'b0;
            gnt_data_q  <= 1'b0;
            last_data_q <= 1'b0;
            cnt_q       <= '0;
            addr_q      <= 30'h0;
            wr_val_q    <= 32'h0;
            wr_en_q     <= 1'b0;
            bytesel_q   <= 4'h0;
            rdata_q     <= 32'h0;
            rerr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            i_pend_q    <= i_pend_d;
            d_pend_q    <= d_pend_d;
            gnt_data_q  <= gnt_data_d;
            last_data_q <= last_data_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wr_val_q    <= wr_val_d;
            wr_en_q     <= wr_en_d;
            bytesel_q   <= bytesel_d;
            rdata_q     <= rdata_d;
            rerr_q      <= rerr_d;
        end
    end

endmodule

// File: tb/tb_keynsham_bus_arbiter.sv
// Randomized scoreboard bench for keynsham_bus_arbiter.
// The driver issues master requests and plays a slave; the reference model tracks
// queued requests, round-robin order and slave responses, and pushes the expected
// completion of each granted transaction; the monitor compares on every cycle.
module tb_keynsham_bus_arbiter;

    localparam int unsigned TIMEOUT = 4;
    localparam int unsigned CNT_W   = 3;
    localparam int          RUN_CYC = 1500;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_access;
    logic [29:0] i_addr;
    logic [31:0] i_data;
    logic        i_ack;
    logic        i_error;
    logic        d_access;
    logic [29:0] d_addr;
    logic [31:0] d_wr_val;
    logic        d_wr_en;
    logic [3:0]  d_bytesel;
    logic [31:0] d_data;
    logic        d_ack;
    logic        d_error;
    logic        m_access;
    logic [29:0] m_addr;
    logic [31:0] m_wr_val;
    logic        m_wr_en;
    logic [3:0]  m_bytesel;
    logic [31:0] m_data;
    logic        m_ack;
    logic        m_error;

    keynsham_bus_arbiter #(
        .TIMEOUT(TIMEOUT),
        .CNT_W  (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .i_access (i_access),
        .i_addr   (i_addr),
        .i_data   (i_data),
        .i_ack    (i_ack),
        .i_error  (i_error),
        .d_access (d_access),
        .d_addr   (d_addr),
        .d_wr_val (d_wr_val),
        .d_wr_en  (d_wr_en),
        .d_bytesel(d_bytesel),
        .d_data   (d_data),
        .d_ack    (d_ack),
        .d_error  (d_error),
        .m_access (m_access),
        .m_addr   (m_addr),
        .m_wr_val (m_wr_val),
        .m_wr_en  (m_wr_en),
        .m_bytesel(m_bytesel),
        .m_data   (m_data),
        .m_ack    (m_ack),
        .m_error  (m_error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [29:0] addr;
        logic [31:0] wr_val;
        logic        wr_en;
        logic [3:0]  bsel;
        int          issue;
    } req_t;

    typedef struct {
        bit          is_d;
        logic [31:0] data;
        logic        err;
        int          cyc;
    } rsp_t;

    req_t        iq[$];
    req_t        dq[$];
    rsp_t        exq[$];
    int          i_own = 0;
    int          d_own = 0;
    bit          busy = 1'b0;
    bit          last_d = 1'b0;
    int          free_cyc = 0;
    int          sl_due = -100;
    int          late_due = -100;
    logic [31:0] sl_data = 32'h0;
    logic        sl_err = 1'b0;
    logic [66:0] held = '0;
    bit          force_both = 1'b0;
    bit          quiesce = 1'b0;
    int          n_chk = 0;
    int          n_fail = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic reset_model();
        iq.delete();
        dq.delete();
        exq.delete();
        i_own    = 0;
        d_own    = 0;
        busy     = 1'b0;
        last_d   = 1'b0;
        free_cyc = 0;
        sl_due   = -100;
        late_due = -100;
        held     = '0;
    endtask

    // Slave behaviour for a transaction granted at cycle c: either acks within the
    // watchdog window (possibly on its last cycle) or stays silent and acks late.
    task automatic plan_slave(input bit is_d, input int c);
        rsp_t e;
        e.is_d = is_d;
        if ($urandom_range(0, 5) == 0) begin
            sl_due   = -100;
            late_due = c + int'(TIMEOUT) + 2;
            e.data   = 32'h0;
            e.err    = 1'b1;
            e.cyc    = c + int'(TIMEOUT) + 1;
        end else begin
            sl_due  = c + 1 + int'($urandom_range(0, TIMEOUT - 1));
            sl_data = $urandom;
            sl_err  = ($urandom_range(0, 3) == 0);
            e.data  = sl_data;
            e.err   = sl_err;
            e.cyc   = sl_due + 1;
        end
        exq.push_back(e);
    endtask

    // Drives one cycle of stimulus; called just after the active edge.
    task automatic drive();
        req_t r;
        i_access = 1'b0;
        d_access = 1'b0;
        m_ack    = 1'b0;
        m_error  = 1'($urandom);
        m_data   = $urandom;
        if (cyc == sl_due) begin
            m_ack   = 1'b1;
            m_data  = sl_data;
            m_error = sl_err;
        end else if (cyc == late_due || (m_access && $urandom_range(0, 3) == 0)) begin
            m_ack = 1'b1;
        end
        if (quiesce) return;
        if (force_both || ((i_own == 0 || (i_own == 1 && i_ack)) && $urandom_range(0, 2) == 0)) begin
            i_addr   = 30'($urandom);
            i_access = 1'b1;
            r.addr   = i_addr;
            r.wr_val = 32'h0;
            r.wr_en  = 1'b0;
            r.bsel   = 4'hF;
            r.issue  = cyc;
            iq.push_back(r);
            i_own++;
        end else if (i_own > 0 && !i_ack && $urandom_range(0, 9) == 0) begin
            i_access = 1'b1;
        end
        if (force_both || ((d_own == 0 || (d_own == 1 && d_ack)) && $urandom_range(0, 2) == 0)) begin
            d_addr    = force_both ? 30'h2000010 : 30'($urandom);
            d_wr_en   = force_both ? 1'b0 : 1'($urandom);
            d_wr_val  = $urandom;
            d_bytesel = 4'($urandom);
            d_access  = 1'b1;
            r.addr    = d_addr;
            r.wr_val  = d_wr_val;
            r.wr_en   = d_wr_en;
            r.bsel    = d_bytesel;
            r.issue   = cyc;
            dq.push_back(r);
            d_own++;
        end else if (d_own > 0 && !d_ack && $urandom_range(0, 9) == 0) begin
            d_access = 1'b1;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        drive();
    endtask

    // Monitor: compares every cycle against the model, away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            rsp_t        e;
            req_t        r;
            bit          i_el;
            bit          d_el;
            bit          pick_d;
            bit          exp_acc;
            logic [66:0] fields;

            if (exq.size() > 0 && exq[0].cyc == cyc) begin
                e = exq.pop_front();
                check("ack_i", i_ack, !e.is_d);
                check("ack_d", d_ack, e.is_d);
                check("rsp_data", e.is_d ? d_data : i_data, e.data);
                check("rsp_error", e.is_d ? d_error : i_error, e.err);
                check("other_quiet", e.is_d ? {i_data, i_error} : {d_data, d_error}, 0);
                busy     = 1'b0;
                free_cyc = cyc + 2;
                last_d   = e.is_d;
                if (e.is_d) d_own--;
                else i_own--;
            end else begin
                check("no_ack", {i_ack, d_ack}, 0);
                check("idle_zero", {i_data, i_error, d_data, d_error}, 0);
            end

            i_el    = iq.size() > 0 && iq[0].issue <= cyc - 2;
            d_el    = dq.size() > 0 && dq[0].issue <= cyc - 2;
            pick_d  = d_el && (!i_el || !last_d);
            exp_acc = !busy && (i_el || d_el) && cyc >= free_cyc;
            fields  = {m_addr, m_wr_val, m_wr_en, m_bytesel};
            check("m_access", m_access, exp_acc);
            if (m_access && exp_acc) begin
                r = pick_d ? dq.pop_front() : iq.pop_front();
                held = {r.addr, r.wr_val, r.wr_en, r.bsel};
                check("m_fields", fields, held);
                busy = 1'b1;
                plan_slave(pick_d, cyc);
            end else if (!m_access) begin
                check("m_fields_hold", fields, held);
            end
        end
    end

    initial begin
        bit found;
        rst       = 1'b1;
        i_access  = 1'b0;
        i_addr    = 30'h0;
        d_access  = 1'b0;
        d_addr    = 30'h0;
        d_wr_val  = 32'h0;
        d_wr_en   = 1'b0;
        d_bytesel = 4'h0;
        m_data    = 32'h0;
        m_ack     = 1'b0;
        m_error   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {i_ack, i_error, i_data, d_ack, d_error, d_data, m_access,
                                m_addr, m_wr_val, m_wr_en, m_bytesel}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        // Simultaneous first requests: data must win the opening tie.
        force_both = 1'b1;
        drive();
        force_both = 1'b0;
        repeat (RUN_CYC) step();

        // Asynchronous reset while the slave transaction is outstanding.
        found = 1'b0;
        for (int w = 0; w < 200 && !found; w++) begin
            @(posedge clk);
            #1;
            if (busy && !m_access && !i_ack && !d_ack) found = 1'b1;
            else drive();
        end
        check("reset_window", found, 1);
        i_access = 1'b0;
        d_access = 1'b0;
        m_ack    = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("async_reset_outputs", {i_ack, i_error, i_data, d_ack, d_error, d_data, m_access,
                                      m_addr, m_wr_val, m_wr_en, m_bytesel}, 0);
        reset_model();
        @(posedge clk);
        #1;
        rst = 1'b0;
        // A stale slave ack right after reset must be ignored.
        late_due   = cyc;
        force_both = 1'b1;
        drive();
        force_both = 1'b0;
        repeat (RUN_CYC) step();

        quiesce = 1'b1;
        for (int w = 0; w < 100 && (iq.size() + dq.size() + exq.size() > 0 || busy); w++) step();
        repeat (3) step();
        check("drained", iq.size() + dq.size() + exq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
